// File: rtl/rr_arbiter_bin.sv
// rr_arbiter_bin: round-robin arbiter presenting the winner as a binary index with valid/ready
module rr_arbiter_bin #(
   parameter int NUM_REQ = 16,
   parameter int IDX_W   = 4
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [NUM_REQ-1:0] req_i,
   input  logic               gnt_ready_i,
   output logic               gnt_valid_o,
   output logic [IDX_W-1:0]   gnt_idx_o,
   output logic [IDX_W-1:0]   ptr_o
);
   typedef enum logic {IDLE, GRANT} state_t;
   localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_REQ - 1);
   state_t state, state_nxt;
   logic [IDX_W-1:0] ptr, ptr_nxt, win, idx_nxt;
   logic [2**IDX_W-1:0] req_p;
   logic hs, found, load;
   assign hs = (state == GRANT) && gnt_ready_i;
   assign ptr_nxt = hs ? ((gnt_idx_o == LAST) ? '0 : gnt_idx_o + 1'b1) : ptr;
   assign load = (state == IDLE) || hs;
   assign gnt_valid_o = (state == GRANT);
   assign ptr_o = ptr;
   // scan requests ascending from the (possibly just-advanced) pointer, wrapping at NUM_REQ-1
   always_comb begin
      logic [IDX_W-1:0] scan;
      req_p = '0;
      req_p[NUM_REQ-1:0] = req_i;
      found = 1'b0;
      win = '0;
      scan = ptr_nxt;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (!found && req_p[scan]) begin
            found = 1'b1;
            win = scan;
         end
         scan = (scan == LAST) ? '0 : scan + 1'b1;
      end
   end
   // load a new winner from IDLE or on a handshake; otherwise the grant stays frozen
   always_comb begin
      state_nxt = load ? (found ? GRANT : IDLE) : GRANT;
      idx_nxt = (load && found) ? win : gnt_idx_o;
   end
   // state, pointer and grant index registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         ptr <= '0;
         gnt_idx_o <= '0;
      end else begin
         state <= state_nxt;
         ptr <= ptr_nxt;
         gnt_idx_o <= idx_nxt;
      end
   end
endmodule

// File: tb/tb_rr_arbiter_bin.sv
// tb_rr_arbiter_bin: directed vector bench for the round-robin binary arbiter
module tb_rr_arbiter_bin;
   logic clk = 1'b0;
   logic reset = 1'b1;
   logic [15:0] req = '0;
   logic ready = 1'b0;
   logic valid;
   logic [3:0] idx, ptr;
   logic [4:0] req_b = '0;
   logic ready_b = 1'b0;
   logic valid_b;
   logic [2:0] idx_b, ptr_b;
   int checks = 0;
   int errors = 0;

   typedef struct {
      logic        rst;
      logic [15:0] req;
      logic        rdy;
      logic        v;
      logic [3:0]  i;
      logic [3:0]  p;
   } vec_t;
   vec_t tbl[$];

   rr_arbiter_bin #(.NUM_REQ(16), .IDX_W(4)) dut (
      .clk(clk), .reset(reset), .req_i(req), .gnt_ready_i(ready),
      .gnt_valid_o(valid), .gnt_idx_o(idx), .ptr_o(ptr)
   );

   rr_arbiter_bin #(.NUM_REQ(5), .IDX_W(3)) dut5 (
      .clk(clk), .reset(reset), .req_i(req_b), .gnt_ready_i(ready_b),
      .gnt_valid_o(valid_b), .gnt_idx_o(idx_b), .ptr_o(ptr_b)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic add(input logic r, input logic [15:0] q, input logic y,
                      input logic v, input logic [3:0] i, input logic [3:0] p);
      tbl.push_back('{rst: r, req: q, rdy: y, v: v, i: i, p: p});
   endtask

   initial begin
      // reset with all requests pending
      add(1, 16'hFFFF, 1, 0, 0, 0);
      add(1, 16'hFFFF, 1, 0, 0, 0);
      // single requester re-granted every cycle
      add(0, 16'h0001, 1, 1, 0, 0);
      add(0, 16'h0001, 1, 1, 0, 1);
      add(0, 16'h0001, 1, 1, 0, 1);
      add(1, 16'h0000, 0, 0, 0, 0);
      // back-to-back round robin with wrap
      add(0, 16'h8421, 1, 1, 0, 0);
      add(0, 16'h8421, 1, 1, 5, 1);
      add(0, 16'h8421, 1, 1, 10, 6);
      add(0, 16'h8421, 1, 1, 15, 11);
      add(0, 16'h8421, 1, 1, 0, 0);
      add(0, 16'h8421, 1, 1, 5, 1);
      add(1, 16'h0000, 0, 0, 0, 0);
      // grant held without ready, not retracted when request drops
      add(0, 16'h0018, 0, 1, 3, 0);
      for (int n = 0; n < 4; n++) add(0, 16'h0018, 0, 1, 3, 0);
      add(0, 16'h0000, 0, 1, 3, 0);
      add(0, 16'h0000, 1, 0, 3, 4);
      add(0, 16'h0000, 1, 0, 3, 4);
      add(0, 16'h0010, 0, 1, 4, 4);
      add(0, 16'hFFFF, 0, 1, 4, 4);
      add(0, 16'hFFFF, 1, 1, 5, 5);
      add(1, 16'h0000, 0, 0, 0, 0);

      #1;
      foreach (tbl[n]) begin
         reset = tbl[n].rst;
         req = tbl[n].req;
         ready = tbl[n].rdy;
         @(posedge clk);
         #1;
         chk($sformatf("row%0d valid", n), 32'(valid), 32'(tbl[n].v));
         if (tbl[n].v || tbl[n].rst) chk($sformatf("row%0d idx", n), 32'(idx), 32'(tbl[n].i));
         chk($sformatf("row%0d ptr", n), 32'(ptr), 32'(tbl[n].p));
      end

      // asynchronous reset while a grant is pending
      reset = 1'b0;
      req = 16'h0080;
      ready = 1'b0;
      @(posedge clk);
      #1;
      chk("rst_pre valid", 32'(valid), 32'd1);
      chk("rst_pre idx", 32'(idx), 32'd7);
      @(negedge clk);
      reset = 1'b1;
      #1;
      chk("async valid", 32'(valid), 32'd0);
      chk("async idx", 32'(idx), 32'd0);
      chk("async ptr", 32'(ptr), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      #1;
      chk("post_rst valid", 32'(valid), 32'd1);
      chk("post_rst idx", 32'(idx), 32'd7);
      chk("post_rst ptr", 32'(ptr), 32'd0);

      // five requesters: 0 and 4 alternate, pointer stays below NUM_REQ
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      req = '0;
      req_b = 5'b10001;
      ready_b = 1'b1;
      for (int n = 0; n < 8; n++) begin
         @(posedge clk);
         #1;
         chk($sformatf("n5 valid%0d", n), 32'(valid_b), 32'd1);
         chk($sformatf("n5 idx%0d", n), 32'(idx_b), (n % 2 == 0) ? 32'd0 : 32'd4);
         chk($sformatf("n5 ptr%0d", n), 32'(ptr_b), (n == 0) ? 32'd0 : ((n % 2 == 1) ? 32'd1 : 32'd0));
         if (ptr_b > 3'd4) chk($sformatf("n5 ptr_range%0d", n), 32'(ptr_b), 32'd4);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
